device_serial_tx: RTL and testbench

- Character output device directly downstream of the memory-mapped monitor intercept stage.
- Consumes the 32-bit word forwarded on dataDeviceOut when the CPU stores to the device address 0x0000FFF8.
- Serialises the word as up to 4 UART-style 8N1 bytes, least-significant byte first.
- Returns a one-cycle dataDeviceFinish pulse so the monitor stage clears the status word at 0x0000FFFC.

---
 rtl/device_serial_tx.sv | 168 ++++++++++++++++
 tb/tb_device_serial_tx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/device_serial_tx.sv
// device_serial_tx
//   Character output device fed by the monitor intercept stage. A store to the
//   device address delivers a 32-bit word, which is sent as up to four 8N1
//   frames, least-significant byte first. A one-cycle finish pulse tells the
//   monitor stage to clear its status word.
//
// Ports
//   clock            system clock, rising edge
//   resetN           asynchronous active-low reset
//   startIn          one-cycle strobe, dataDeviceIn holds a new word
//   dataDeviceIn     word to transmit
//   txOut            serial line, idle high
//   busyOut          high while a word is in progress
//   dataDeviceFinish one-cycle pulse when the word is complete
//   overrunOut       sticky, a start arrived while not idle and was dropped
//
// State  | meaning
// -------+--------------------------------------------------------------
// IDLE   | line idle, waiting for startIn
// START  | start bit (line low)
// DATA   | 8 data bits, LSB first
// STOP   | stop bit, all but its final cycle
// NEXT   | final stop-bit cycle; selects next byte or ends the word
// DONE   | finish pulse cycle

module device_serial_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_ON_NUL  = 1
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        startIn,
  input  logic [31:0] dataDeviceIn,
  output logic        txOut,
  output logic        busyOut,
  output logic        dataDeviceFinish,
  output logic        overrunOut
);

  localparam int TMR_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST      = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] TMR_STOP_LAST = TMR_W'(CLKS_PER_BIT - 2);
  localparam bit NUL_ENDS = (STOP_ON_NUL != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_NEXT, S_DONE
  } state_t;

  state_t           r_state,  w_state_nxt;
  logic [TMR_W-1:0] r_tmr,    w_tmr_nxt;
  logic [2:0]       r_bit,    w_bit_nxt;
  logic [1:0]       r_idx,    w_idx_nxt;
  logic [31:0]      r_word,   w_word_nxt;
  logic             r_tx,     w_tx_nxt;
  logic             r_busy,   w_busy_nxt;
  logic             r_fin,    w_fin_nxt;
  logic             r_ovr,    w_ovr_nxt;

  logic [1:0] w_idx_inc;
  logic [7:0] w_next_byte;
  logic [7:0] w_cur_byte;

  assign w_idx_inc   = r_idx + 2'd1;
  assign w_next_byte = r_word[{w_idx_inc, 3'b000} +: 8];

  // State register (outputs are registered alongside the state)
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
      r_bit   <= '0;
      r_idx   <= '0;
      r_word  <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_fin   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
      r_bit   <= w_bit_nxt;
      r_idx   <= w_idx_nxt;
      r_word  <= w_word_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      r_fin   <= w_fin_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_bit_nxt   = r_bit;
    w_idx_nxt   = r_idx;
    w_word_nxt  = r_word;
    case (r_state)
      S_IDLE: begin
        if (startIn) begin
          w_word_nxt = dataDeviceIn;
          w_tmr_nxt  = '0;
          w_bit_nxt  = '0;
          w_idx_nxt  = 2'd0;
          if (NUL_ENDS && (dataDeviceIn[7:0] == 8'h00)) begin
            // Empty string: spend one cycle in NEXT as if on the last byte,
            // so the finish pulse lands one cycle after acceptance.
            w_idx_nxt   = 2'd3;
            w_state_nxt = S_NEXT;
          end else begin
            w_state_nxt = S_START;
          end
        end
      end
      S_START: begin
        if (r_tmr == TMR_LAST) begin
          w_tmr_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      S_DATA: begin
        if (r_tmr == TMR_LAST) begin
          w_tmr_nxt = '0;
          if (r_bit == 3'd7) w_state_nxt = S_STOP;
          else               w_bit_nxt   = r_bit + 3'd1;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      S_STOP: begin
        w_tmr_nxt = r_tmr + 1'b1;
        if (r_tmr == TMR_STOP_LAST) w_state_nxt = S_NEXT;
      end
      S_NEXT: begin
        w_tmr_nxt = '0;
        w_idx_nxt = w_idx_inc;
        if (r_idx == 2'd3)                             w_state_nxt = S_DONE;
        else if (NUL_ENDS && (w_next_byte == 8'h00))   w_state_nxt = S_DONE;
        else                                           w_state_nxt = S_START;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: computed from the upcoming state so the registered outputs
  // line up with the state they describe.
  always_comb begin
    w_cur_byte = w_word_nxt[{w_idx_nxt, 3'b000} +: 8];
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_cur_byte[w_bit_nxt];
      default: w_tx_nxt = 1'b1;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_fin_nxt  = (w_state_nxt == S_DONE);
    w_ovr_nxt  = r_ovr | (startIn && (r_state != S_IDLE));
  end

  assign txOut            = r_tx;
  assign busyOut          = r_busy;
  assign dataDeviceFinish = r_fin;
  assign overrunOut       = r_ovr;

endmodule

// File: tb/tb_device_serial_tx.sv
// Testbench for device_serial_tx: two instances with CLKS_PER_BIT=4, one with
// NUL termination (inst 0) and one always sending four bytes (inst 1).
module tb_device_serial_tx;

  localparam int CPB = 4;

  logic        clock;
  logic        resetN;
  logic        start0, start1;
  logic [31:0] din0, din1;
  wire         tx0, busy0, fin0, ovr0;
  wire         tx1, busy1, fin1, ovr1;

  int n_checks = 0;
  int n_err    = 0;
  int exp_ovr[2];

  device_serial_tx #(.CLKS_PER_BIT(CPB), .STOP_ON_NUL(1)) dut_nul (
    .clock(clock), .resetN(resetN), .startIn(start0), .dataDeviceIn(din0),
    .txOut(tx0), .busyOut(busy0), .dataDeviceFinish(fin0), .overrunOut(ovr0)
  );

  device_serial_tx #(.CLKS_PER_BIT(CPB), .STOP_ON_NUL(0)) dut_all (
    .clock(clock), .resetN(resetN), .startIn(start1), .dataDeviceIn(din1),
    .txOut(tx1), .busyOut(busy1), .dataDeviceFinish(fin1), .overrunOut(ovr1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          inst;
    logic [31:0] word;
    int          ovr_at;   // cycle after E0 in which a second start is driven, -1 none
    int          exp_fin;  // cycle after E0 holding the finish pulse
  } vec_t;

  function automatic logic get_tx(int i);   return (i == 0) ? tx0   : tx1;   endfunction
  function automatic logic get_busy(int i); return (i == 0) ? busy0 : busy1; endfunction
  function automatic logic get_fin(int i);  return (i == 0) ? fin0  : fin1;  endfunction
  function automatic logic get_ovr(int i);  return (i == 0) ? ovr0  : ovr1;  endfunction

  task automatic set_start(int i, logic v);
    if (i == 0) start0 = v; else start1 = v;
  endtask

  task automatic set_din(int i, logic [31:0] v);
    if (i == 0) din0 = v; else din1 = v;
  endtask

  task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  // Reference model: number of bytes sent for a word.
  function automatic int count_bytes(logic [31:0] w, bit nul);
    int n = 0;
    for (int b = 0; b < 4; b++) begin
      logic [31:0] sh = w >> (8 * b);
      if (nul && sh[7:0] == 8'h00) break;
      n++;
    end
    return n;
  endfunction

  // Reference model: expected line level k cycles after acceptance.
  function automatic logic exp_tx(logic [31:0] w, int n, int k);
    int frame, pos;
    logic [31:0] sh;
    if (k >= 10 * n * CPB) return 1'b1;
    frame = k / (10 * CPB);
    pos   = (k / CPB) % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    sh = w >> (8 * frame);
    return sh[pos - 1];
  endfunction

  task automatic run_word(int inst, logic [31:0] w, int ovr_at, int exp_fin);
    int n, fin_exp, first_fin;
    n = count_bytes(w, inst == 0);
    fin_exp = (exp_fin >= 0) ? exp_fin : ((n > 0) ? 10 * n * CPB : 1);
    first_fin = -1;
    @(posedge clock);
    #1 set_start(inst, 1'b1); set_din(inst, w);
    @(posedge clock);  // E0
    #1 set_start(inst, ovr_at == 0); set_din(inst, $urandom);
    for (int k = 0; k <= fin_exp + 3; k++) begin
      @(negedge clock);
      if (ovr_at >= 0 && k == ovr_at + 1) exp_ovr[inst] = 1;
      chk("tx",      k, 32'(get_tx(inst)),   32'(exp_tx(w, n, k)));
      chk("busy",    k, 32'(get_busy(inst)), 32'(k <= fin_exp));
      chk("finish",  k, 32'(get_fin(inst)),  32'(k == fin_exp));
      chk("overrun", k, 32'(get_ovr(inst)),  32'(exp_ovr[inst]));
      if (get_fin(inst) && first_fin < 0) first_fin = k;
      if (k == ovr_at) set_start(inst, 1'b1);
      if (k == ovr_at + 1) set_start(inst, 1'b0);
    end
    chk("finish_time", 0, 32'(first_fin), 32'(fin_exp));
    set_start(inst, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetN = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_tx",      i, 32'(get_tx(i)),   32'd1);
      chk("rst_busy",    i, 32'(get_busy(i)), 32'd0);
      chk("rst_finish",  i, 32'(get_fin(i)),  32'd0);
      chk("rst_overrun", i, 32'(get_ovr(i)),  32'd0);
      exp_ovr[i] = 0;
    end
    repeat (2) @(negedge clock);
    resetN = 1'b1;
  endtask

  vec_t vecs[$];

  initial begin
    int fin_cnt;
    logic [31:0] w;
    resetN = 1'b1;
    start0 = 1'b0; start1 = 1'b0;
    din0 = '0; din1 = '0;
    exp_ovr[0] = 0; exp_ovr[1] = 0;

    vecs.push_back('{0, 32'h0000_0041, -1, 40});
    vecs.push_back('{0, 32'h0000_4241, -1, 80});
    vecs.push_back('{1, 32'h0000_0000, -1, 160});
    vecs.push_back('{0, 32'h1234_0000, -1, 1});
    vecs.push_back('{0, 32'h0042_0041, -1, 40});
    vecs.push_back('{0, 32'h1122_3344, -1, 160});
    vecs.push_back('{1, 32'h0000_0041, -1, 160});
    vecs.push_back('{0, 32'hFF00_0041, -1, 40});
    vecs.push_back('{0, 32'h0041_4243, -1, 120});
    vecs.push_back('{0, 32'h0000_0041, 20, 40});    // overrun mid-frame
    vecs.push_back('{1, 32'h0000_0041, 160, 160});  // start during DONE

    #3 do_reset();

    // Reset in the middle of a frame.
    @(posedge clock);
    #1 start0 = 1'b1; din0 = 32'h41;
    @(posedge clock);
    #1 start0 = 1'b0;
    for (int k = 0; k <= 13; k++) begin
      @(negedge clock);
      chk("mid_tx", k, 32'(tx0), 32'(exp_tx(32'h41, 1, k)));
    end
    resetN = 1'b0;
    #1;
    chk("mid_rst_tx",      13, 32'(tx0),   32'd1);
    chk("mid_rst_busy",    13, 32'(busy0), 32'd0);
    chk("mid_rst_finish",  13, 32'(fin0),  32'd0);
    chk("mid_rst_overrun", 13, 32'(ovr0),  32'd0);
    repeat (3) @(negedge clock);
    resetN = 1'b1;
    fin_cnt = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (fin0 || busy0) fin_cnt++;
    end
    chk("mid_no_finish", 0, 32'(fin_cnt), 32'd0);

    foreach (vecs[i]) run_word(vecs[i].inst, vecs[i].word, vecs[i].ovr_at, vecs[i].exp_fin);

    // Start held high for two edges while idle: second one is an overrun.
    do_reset();
    run_word(0, 32'h0000_0041, 0, 40);

    // Randomized words against the reference model.
    do_reset();
    for (int r = 0; r < 16; r++) begin
      for (int b = 0; b < 4; b++)
        w[8*b +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      run_word(int'($urandom_range(0, 1)), w, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
